lc3_regfile_pipe: RTL
=====================

LC3_REGFILE_PIPE -- requirements
Module: lc3_regfile_pipe

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register and bus data width.
REQ-002 Parameter NREG, default 8, SHALL set the register count; ADDR_W = clog2(NREG), default 3.
REQ-003 Parameter PEND_W, default 2, SHALL set the width of each register's pending-write counter; max count = 2^PEND_W-1.
REQ-004 clk  in  1  clock; all state SHALL update on rising edge only.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 rd_addr_a, rd_addr_b  in  ADDR_W  read port A/B register select.
REQ-007 rd_data_a, rd_data_b  out  DATA_W  read port A/B data, combinational.
REQ-008 rd_busy_a, rd_busy_b  out  1  selected register has outstanding write(s).
REQ-009 iss_valid  in  1  issue: instruction targeting iss_addr enters pipeline.
REQ-010 iss_addr  in  ADDR_W  destination register of issuing instruction.
REQ-011 iss_ready  out  1  issue accepted this cycle (counter for iss_addr not saturated).
REQ-012 wb_valid, wb_addr, wb_data  in  1/ADDR_W/DATA_W  writeback strobe, destination, value.
REQ-013 cc_ld  in  1  with wb_valid, update condition codes from wb_data.
REQ-014 cc_nzp  out  3  registered N,Z,P flags.
REQ-015 sb_err  out  1  sticky scoreboard error flag.

Function
REQ-016 Reads SHALL be combinational from the array; both ports SHALL serve any address, including the same one.
REQ-017 wb_valid=1 SHALL write wb_data to register wb_addr at the rising edge; 1-cycle write latency.
REQ-018 Each register SHALL own a pending counter; iss_valid&&iss_ready SHALL increment counter[iss_addr]; wb_valid SHALL decrement counter[wb_addr].
REQ-019 Issue and writeback to the same register in one cycle SHALL leave that counter unchanged and SHALL be accepted even at saturation.
REQ-020 iss_ready SHALL be 0 when counter[iss_addr] is at max and no same-register writeback occurs this cycle; otherwise 1; a refused issue SHALL change no state.
REQ-021 rd_busy_x SHALL equal (counter[rd_addr_x] != 0).
REQ-022 wb_valid to a register with counter 0 SHALL still write data, SHALL leave counter at 0 (no underflow), and SHALL set sb_err.
REQ-023 cc_ld&&wb_valid SHALL set cc_nzp = 100 if wb_data[DATA_W-1]=1, 010 if wb_data=0, else 001, at the same edge as the write; otherwise cc_nzp holds.
REQ-024 sb_err SHALL remain 1 until reset.

Reset
REQ-025 rst=0 at a rising edge SHALL clear all registers to 0, all counters to 0, sb_err to 0, and set cc_nzp to 010.
REQ-026 Reset SHALL override simultaneous iss_valid and wb_valid; in-flight pending state SHALL be discarded.
REQ-027 During reset iss_ready SHALL follow REQ-020 against the (clearing) counters; read ports SHALL remain combinational.

Configuration
REQ-028 Macro LC3_RF_BYPASS_EN defined: when wb_valid and wb_addr == rd_addr_x, rd_data_x SHALL return wb_data in the same cycle, and rd_busy_x SHALL be 0 if counter[rd_addr_x] == 1 and no same-register issue is accepted that cycle.
REQ-029 LC3_RF_BYPASS_EN undefined: rd_data_x SHALL return pre-write array contents, and rd_busy_x SHALL follow REQ-021 only; new value visible the cycle after writeback.

Verification
REQ-030 Reset, then read all 8 registers -> rd_data 0x0000, rd_busy 0, cc_nzp 010, sb_err 0.
REQ-031 iss R3; next cycle wb R3=0x8001 with cc_ld, rd_addr_a=3 -> busy 1 before wb; after edge R3=0x8001, busy 0, cc_nzp 100.
REQ-032 Issue R5 three times, no wb -> iss_ready 0 on 4th; 4th issue together with wb R5 -> accepted, counter stays 3.
REQ-033 wb R2=0x1234 with rd_addr_a=rd_addr_b=2, count 1 -> with LC3_RF_BYPASS_EN both read 0x1234 and busy 0 same cycle; without, old value, busy 1.
REQ-034 wb R1=0x0000 with counter 0, cc_ld=1 -> R1 written, cc_nzp 010, sb_err 1 and held until rst=0.
REQ-035 rst=0 with two R4 issues pending and wb R4 in same cycle -> R4=0, counter 0, next-cycle rd_busy 0.

Source files
------------

// File: rtl/lc3_regfile_pipe.sv
// LC-3 register file with per-register pending-write scoreboard and N/Z/P condition codes.
// Optional same-cycle writeback bypass on both read ports: define LC3_RF_BYPASS_EN.
module lc3_regfile_pipe #(
  parameter int  DATA_W = 16,
  parameter int  NREG   = 8,
  parameter int  PEND_W = 2,
  localparam int ADDR_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              cc_ld,
  output logic [2:0]        cc_nzp,
  output logic              sb_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [PEND_W-1:0] cnt  [NREG];

  logic              iss_acc;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1])  return 3'b100;
    else if (d == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  // A writeback to the issuing register frees a slot this cycle, so saturation is not a stall.
  assign iss_ready = (cnt[iss_addr] != PEND_MAX) || (wb_valid && (wb_addr == iss_addr));
  assign iss_acc   = iss_valid && iss_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc_vec[i] = iss_acc  && (iss_addr == ADDR_W'(i));
      dec_vec[i] = wb_valid && (wb_addr  == ADDR_W'(i));
    end
  end

`ifdef LC3_RF_BYPASS_EN
  logic byp_a;
  logic byp_b;

  always_comb begin
    byp_a     = wb_valid && (wb_addr == rd_addr_a);
    byp_b     = wb_valid && (wb_addr == rd_addr_b);
    rd_data_a = byp_a ? wb_data : regs[rd_addr_a];
    rd_data_b = byp_b ? wb_data : regs[rd_addr_b];
    // The last outstanding write retiring now clears busy unless a new issue refills it.
    rd_busy_a = (cnt[rd_addr_a] != '0) &&
                !(byp_a && (cnt[rd_addr_a] == PEND_ONE) && !inc_vec[rd_addr_a]);
    rd_busy_b = (cnt[rd_addr_b] != '0) &&
                !(byp_b && (cnt[rd_addr_b] == PEND_ONE) && !inc_vec[rd_addr_b]);
  end
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign rd_busy_a = (cnt[rd_addr_a] != '0);
  assign rd_busy_b = (cnt[rd_addr_b] != '0);
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the architectural registers must read 0 after reset, so the array is reset
      // explicitly here rather than left as uninitialised storage.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      cc_nzp <= 3'b010;
      sb_err <= 1'b0;
    end else begin
      if (wb_valid) begin
        regs[wb_addr] <= wb_data;
        if (cnt[wb_addr] == '0) sb_err <= 1'b1;
        if (cc_ld)              cc_nzp <= nzp_of(wb_data);
      end
      for (int i = 0; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + PEND_ONE;
        else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - PEND_ONE;
      end
    end
  end

endmodule
